// File: rtl/tx_pkg.sv
// Shared state encoding and default build constants for the TX stream controller.
package tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        PAD  = 2'd2,
        GAP  = 2'd3
    } tx_state_t;

    localparam int DEF_LEN_W      = 16;
    localparam int DEF_MIN_FRAME  = 64;
    localparam int DEF_MAX_FRAME  = 1518;
    localparam int DEF_PAD_EN     = 1;
    localparam int DEF_IFG_CYCLES = 12;

endpackage

// File: rtl/tx_prefetch_buf.sv
// Two-entry byte prefetch FIFO with occupancy count; simultaneous push and pop allowed.
// Latency: push visible at head the next cycle; caller must never push when full.
module tx_prefetch_buf (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] push_data,
    input  logic       pop,
    output logic [7:0] head,
    output logic [1:0] count
);

    logic [7:0] mem [2];
    logic       wr_ptr;
    logic       rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = mem[rd_ptr];

endmodule

// File: rtl/tx_stream_ctrl.sv
// Frame sender: pulls frm_len bytes from a read-latency-1 buffer, pads to MIN_FRAME, then idles IFG.
// Latency: first byte valid 2 cycles after accepted start; output held stable while MAC stalls.
module tx_stream_ctrl
    import tx_pkg::*;
#(
    parameter int LEN_W      = DEF_LEN_W,
    parameter int MIN_FRAME  = DEF_MIN_FRAME,
    parameter int MAX_FRAME  = DEF_MAX_FRAME,
    parameter int PAD_EN     = DEF_PAD_EN,
    parameter int IFG_CYCLES = DEF_IFG_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frm_start,
    input  logic [LEN_W-1:0] frm_len,
    input  logic [7:0]       rd_data,
    input  logic             empty_buff,
    output logic             rd_en,
    output logic [7:0]       tx_data_o,
    output logic             valid_flag,
    output logic             last_byte,
    input  logic             tx_mac_ready,
    output logic             busy,
    output logic             len_err,
    output logic             underrun
);

    localparam logic [LEN_W-1:0] ONE      = LEN_W'(1);
    localparam logic [LEN_W-1:0] MIN_LEN  = LEN_W'(MIN_FRAME);
    localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(MAX_FRAME);
    localparam logic [LEN_W-1:0] GAP_LAST = LEN_W'(IFG_CYCLES - 1);

    tx_state_t        state, state_nxt;
    logic [LEN_W-1:0] len_q, req_cnt, ld_cnt, xfer_cnt, gap_cnt, tot_len;
    logic             len_bad, accept, need_pad, active, xfer, take, inflight;
    logic             ld_pf, ld_byp, ld_pad, any_ld;
    logic             pf_push, pf_pop;
    logic [7:0]       pf_head;
    logic [1:0]       pf_count;

    tx_prefetch_buf u_prefetch (
        .clk       (clk),
        .rst       (rst),
        .push      (pf_push),
        .push_data (rd_data),
        .pop       (pf_pop),
        .head      (pf_head),
        .count     (pf_count)
    );

    // Output register reloads whenever it is empty or being taken: queued byte first,
    // then a byte arriving straight from the buffer, then pad zeros once payload is exhausted.
    always_comb begin
        len_bad  = (frm_len == '0) || (frm_len > MAX_LEN);
        accept   = (state == IDLE) && frm_start && !len_bad;
        need_pad = (PAD_EN != 0) && (len_q < MIN_LEN);
        tot_len  = need_pad ? MIN_LEN : len_q;
        active   = (state == SEND) || (state == PAD);
        xfer     = valid_flag && tx_mac_ready;
        take     = !valid_flag || tx_mac_ready;
        ld_pf    = active && take && (pf_count != 2'd0);
        ld_byp   = active && take && (pf_count == 2'd0) && inflight;
        ld_pad   = active && take && (pf_count == 2'd0) && !inflight
                   && (ld_cnt >= len_q) && (ld_cnt < tot_len);
        any_ld   = ld_pf || ld_byp || ld_pad;
        pf_pop   = ld_pf;
        pf_push  = inflight && !ld_byp;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = SEND;
            SEND: if (xfer && (xfer_cnt == len_q - ONE)) state_nxt = need_pad ? PAD : GAP;
            PAD:  if (xfer && (xfer_cnt == tot_len - ONE)) state_nxt = GAP;
            GAP:  if (gap_cnt == GAP_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state != IDLE);
        rd_en = (state == SEND) && !empty_buff && (req_cnt < len_q)
                && ((pf_count + {1'b0, inflight}) < 2'd2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q      <= '0;
            req_cnt    <= '0;
            ld_cnt     <= '0;
            xfer_cnt   <= '0;
            gap_cnt    <= '0;
            inflight   <= 1'b0;
            tx_data_o  <= 8'h00;
            valid_flag <= 1'b0;
            last_byte  <= 1'b0;
            len_err    <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            len_err  <= (state == IDLE) && frm_start && len_bad;
            inflight <= rd_en;
            gap_cnt  <= (state == GAP) ? gap_cnt + ONE : '0;
            if (accept) begin
                len_q    <= frm_len;
                req_cnt  <= '0;
                ld_cnt   <= '0;
                xfer_cnt <= '0;
            end else begin
                if (rd_en)  req_cnt  <= req_cnt + ONE;
                if (any_ld) ld_cnt   <= ld_cnt + ONE;
                if (xfer)   xfer_cnt <= xfer_cnt + ONE;
            end
            if (any_ld) begin
                valid_flag <= 1'b1;
                tx_data_o  <= ld_pf ? pf_head : (ld_byp ? rd_data : 8'h00);
                last_byte  <= (ld_cnt + ONE == tot_len);
            end else if (take) begin
                valid_flag <= 1'b0;
                last_byte  <= 1'b0;
            end
            // Only a stall the buffer actually caused counts, not the startup fill.
            if ((state == SEND) && !valid_flag && (pf_count == 2'd0) && !inflight
                && empty_buff && (req_cnt < len_q)) begin
                underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tx_stream_ctrl.sv
// Scoreboarded bench: a byte-level reference of each frame is queued at start and checked by a monitor.
module tb_tx_stream_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        frm_start;
    logic [15:0] frm_len;
    logic [7:0]  rd_data;
    logic        empty_buff;
    logic        tx_mac_ready;
    logic        rd_en, valid_flag, last_byte, busy, len_err, underrun;
    logic [7:0]  tx_data_o;
    logic        np_rd_en, np_vld, np_last, np_busy, np_len_err, np_underrun;
    logic [7:0]  np_data;

    int          n_vec = 0;
    int          n_err = 0;
    int          n_rd = 0;
    int          n_xfer = 0;
    int          rdy_mode = 0;
    logic        hold_empty = 1'b0;
    logic [7:0]  mem [8192];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    logic        buf_fire;
    logic [8:0]  exp_q [$];
    int          np_exp [$];

    always #5 clk = ~clk;

    assign empty_buff = hold_empty || (rd_ptr >= wr_ptr);

    tx_stream_ctrl u_dut (
        .clk(clk), .rst(rst), .frm_start(frm_start), .frm_len(frm_len),
        .rd_data(rd_data), .empty_buff(empty_buff), .rd_en(rd_en),
        .tx_data_o(tx_data_o), .valid_flag(valid_flag), .last_byte(last_byte),
        .tx_mac_ready(tx_mac_ready), .busy(busy), .len_err(len_err), .underrun(underrun)
    );

    tx_stream_ctrl #(.PAD_EN(0)) u_dut_np (
        .clk(clk), .rst(rst), .frm_start(frm_start), .frm_len(frm_len),
        .rd_data(rd_data), .empty_buff(empty_buff), .rd_en(np_rd_en),
        .tx_data_o(np_data), .valid_flag(np_vld), .last_byte(np_last),
        .tx_mac_ready(tx_mac_ready), .busy(np_busy), .len_err(np_len_err), .underrun(np_underrun)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: unexpected event at %0t", name, $time);
    endtask

    // External buffer: data appears one cycle after the read strobe; reset empties it.
    initial begin
        rd_data = 8'h00;
        forever begin
            @(negedge clk);
            buf_fire = rd_en;
            @(posedge clk);
            #1;
            if (!rst) begin
                rd_ptr = wr_ptr;
            end else if (buf_fire) begin
                rd_data = mem[rd_ptr % 8192];
                rd_ptr++;
            end
        end
    end

    initial begin
        tx_mac_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                1:       tx_mac_ready = !tx_mac_ready;
                2:       tx_mac_ready = 1'($urandom_range(0, 1));
                default: tx_mac_ready = 1'b1;
            endcase
        end
    end

    initial begin : monitor
        logic       stall;
        logic [8:0] held;
        logic [8:0] e;
        int         np_cnt;
        stall  = 1'b0;
        held   = '0;
        np_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                stall  = 1'b0;
                np_cnt = 0;
            end else begin
                if (rd_en) n_rd++;
                check("np_rd_en", 32'(np_rd_en), 32'(rd_en));
                check("np_len_err", 32'(np_len_err), 32'(len_err));
                check("np_underrun", 32'(np_underrun), 32'(underrun));
                if (stall) begin
                    check("hold_valid", 32'(valid_flag), 32'd1);
                    check("hold_byte", 32'({last_byte, tx_data_o}), 32'(held));
                end
                if (valid_flag && tx_mac_ready) begin
                    if (exp_q.size() == 0) begin
                        flag_fail("spurious_byte");
                    end else begin
                        e = exp_q.pop_front();
                        check("byte", 32'({last_byte, tx_data_o}), 32'(e));
                        n_xfer++;
                    end
                end
                stall = valid_flag && !tx_mac_ready;
                held  = {last_byte, tx_data_o};
                if (np_vld && tx_mac_ready) begin
                    np_cnt++;
                    check("np_data", 32'(np_data), 32'(tx_data_o));
                    if (np_last) begin
                        if (np_exp.size() == 0) flag_fail("np_spurious_last");
                        else check("np_last_pos", 32'(np_cnt), 32'(np_exp.pop_front()));
                        np_cnt = 0;
                    end
                end
            end
        end
    end

    // Reference: payload bytes in order, zero-filled up to 64 bytes, last flag on the final byte.
    task automatic start_frame(input int len);
        int         tot;
        logic [7:0] b;
        @(posedge clk);
        #1;
        tot = (len < 64) ? 64 : len;
        for (int i = 0; i < tot; i++) begin
            if (i < len) begin
                b = 8'($urandom);
                mem[wr_ptr % 8192] = b;
                wr_ptr++;
            end else begin
                b = 8'h00;
            end
            exp_q.push_back({(i == tot - 1), b});
        end
        np_exp.push_back(len);
        n_xfer = 0;
        n_rd   = 0;
        frm_start = 1'b1;
        frm_len   = 16'(len);
        @(posedge clk);
        #1;
        frm_start = 1'b0;
        @(negedge clk);
        check("busy_on_accept", 32'(busy), 32'd1);
        @(negedge clk);
        check("first_valid_early", 32'(valid_flag), 32'd0);
        @(negedge clk);
        check("first_valid_2cyc", 32'(valid_flag), 32'd1);
    endtask

    task automatic finish_frame(input int len, input bit probe);
        bit found;
        bit vbad;
        int gap;
        found = 1'b0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge clk);
            if (valid_flag && tx_mac_ready && last_byte) begin
                found = 1'b1;
                break;
            end
        end
        check("last_seen", 32'(found), 32'd1);
        gap  = 0;
        vbad = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!busy) break;
            gap++;
            if (valid_flag) vbad = 1'b1;
            if (probe && gap == 12) begin
                frm_start = 1'b1;
                frm_len   = 16'd5;
            end
        end
        frm_start = 1'b0;
        check("ifg_cycles", 32'(gap), 32'd12);
        check("gap_valid_low", 32'(vbad), 32'd0);
        @(negedge clk);
        if (probe) check("last_gap_start_ignored", 32'(busy), 32'd0);
        check("rd_en_count", 32'(n_rd), 32'(len));
        check("exp_drained", 32'(exp_q.size()), 32'd0);
        check("np_drained", 32'(np_exp.size()), 32'd0);
        check("np_idle", 32'(np_busy), 32'd0);
    endtask

    task automatic bad_len(input int len);
        @(posedge clk);
        #1;
        n_rd      = 0;
        frm_start = 1'b1;
        frm_len   = 16'(len);
        @(posedge clk);
        #1;
        frm_start = 1'b0;
        @(negedge clk);
        check("len_err_pulse", 32'(len_err), 32'd1);
        check("len_err_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("len_err_one_cycle", 32'(len_err), 32'd0);
        repeat (3) @(negedge clk);
        check("len_err_idle", 32'(busy), 32'd0);
        check("len_err_no_rd", 32'(n_rd), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rd_en"}, 32'(rd_en), 32'd0);
        check({tag, "_valid"}, 32'(valid_flag), 32'd0);
        check({tag, "_last"}, 32'(last_byte), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_len_err"}, 32'(len_err), 32'd0);
        check({tag, "_underrun"}, 32'(underrun), 32'd0);
        check({tag, "_data"}, 32'(tx_data_o), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  len;
        bit  reached;
        rst       = 1'b0;
        frm_start = 1'b0;
        frm_len   = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        start_frame(64);
        finish_frame(64, 1'b1);
        start_frame(10);
        finish_frame(10, 1'b0);

        rdy_mode = 1;
        start_frame(70);
        @(posedge clk);
        #1;
        frm_start = 1'b1;
        frm_len   = 16'd0;
        @(posedge clk);
        #1;
        frm_start = 1'b0;
        @(negedge clk);
        check("busy_start_ignored", 32'(len_err), 32'd0);
        finish_frame(70, 1'b0);
        rdy_mode = 0;

        bad_len(0);
        bad_len(1519);
        start_frame(1);
        finish_frame(1, 1'b0);
        start_frame(1518);
        finish_frame(1518, 1'b0);

        rdy_mode = 2;
        for (int k = 0; k < 6; k++) begin
            len = $urandom_range(1, 200);
            start_frame(len);
            finish_frame(len, 1'b0);
        end
        rdy_mode = 0;
        check("underrun_clear", 32'(underrun), 32'd0);

        start_frame(100);
        reached = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #1;
            if (n_xfer >= 20) begin
                reached = 1'b1;
                break;
            end
        end
        check("stall_point", 32'(reached), 32'd1);
        hold_empty = 1'b1;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("stall_valid_low", 32'(valid_flag), 32'd0);
        check("underrun_set", 32'(underrun), 32'd1);
        hold_empty = 1'b0;
        finish_frame(100, 1'b0);
        check("underrun_sticky", 32'(underrun), 32'd1);

        start_frame(100);
        reached = 1'b0;
        for (int c = 0; c < 500; c++) begin
            @(posedge clk);
            #1;
            if (n_xfer >= 30) begin
                reached = 1'b1;
                break;
            end
        end
        check("reset_point", 32'(reached), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        np_exp.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("post_reset_busy", 32'(busy), 32'd0);
        start_frame(40);
        finish_frame(40, 1'b0);
        check("clean_frame_underrun", 32'(underrun), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tx_stream_ctrl.md
TX_STREAM_CTRL -- requirements
Module: tx_stream_ctrl

Interface
REQ-001 Parameter LEN_W, default 16, width of length fields and byte counter.
REQ-002 Parameter MIN_FRAME, default 64, minimum bytes emitted per frame.
REQ-003 Parameter MAX_FRAME, default 1518, largest accepted frm_len.
REQ-004 Parameter PAD_EN, default 1; 1 = zero-pad short frames to MIN_FRAME, 0 = send frm_len bytes only.
REQ-005 Parameter IFG_CYCLES, default 12, idle cycles enforced after every frame.
REQ-006 clk  in  1  sole clock, all logic on rising edge.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 frm_start  in  1  one-cycle request to send a frame of frm_len bytes.
REQ-009 frm_len  in  LEN_W  payload byte count, sampled when frm_start is accepted.
REQ-010 rd_data  in  8  buffer read data, valid one cycle after rd_en.
REQ-011 empty_buff  in  1  buffer has no readable byte.
REQ-012 rd_en  out  1  pop one byte from buffer.
REQ-013 tx_data_o  out  8  byte to MAC.
REQ-014 valid_flag  out  1  tx_data_o valid.
REQ-015 last_byte  out  1  marks final byte of frame, qualified by valid_flag.
REQ-016 tx_mac_ready  in  1  MAC accepts byte when valid_flag && tx_mac_ready.
REQ-017 busy  out  1  high from accepted frm_start until end of IFG.
REQ-018 len_err  out  1  one-cycle pulse on rejected frm_start.
REQ-019 underrun  out  1  sticky; set when buffer empty stalls an active frame.

Function
REQ-020 States: IDLE, SEND, PAD, GAP.
REQ-021 frm_start accepted only in IDLE; ignored otherwise, no side effects.
REQ-022 frm_start with frm_len == 0 or frm_len > MAX_FRAME: len_err pulse next cycle, stay IDLE, no rd_en.
REQ-023 Accepted start: latch frm_len, go SEND, busy high next cycle.
REQ-024 rd_en asserted only when !empty_buff, bytes-requested < latched length, and prefetch occupancy plus in-flight reads < 2.
REQ-025 Prefetch storage is 2 entries, guaranteeing one byte per cycle with tx_mac_ready held high.
REQ-026 With buffer non-empty, first valid_flag exactly 2 cycles after the accepting edge.
REQ-027 While valid_flag && !tx_mac_ready, tx_data_o, valid_flag and last_byte hold stable.
REQ-028 valid_flag deasserts only after a transfer with no further byte ready, or at frame end.
REQ-029 In SEND, if the prefetch is empty and payload remains, valid_flag low and underrun set; resume when data arrives.
REQ-030 After last payload transfer: PAD_EN=1 and frm_len < MIN_FRAME go PAD, else GAP.
REQ-031 PAD emits 8'h00 bytes under the same handshake until MIN_FRAME bytes total transferred.
REQ-032 last_byte high on exactly one transferred byte: payload byte frm_len, or pad byte MIN_FRAME when padding.
REQ-033 GAP lasts IFG_CYCLES cycles with valid_flag low; then IDLE, busy low.
REQ-034 frm_start in the last GAP cycle is ignored; earliest acceptance is first IDLE cycle.
REQ-035 Byte counter is LEN_W bits and never wraps, as frm_len ≤ MAX_FRAME < 2^LEN_W.
REQ-036 Exactly frm_len rd_en pulses per accepted frame; no reads in PAD, GAP or IDLE.
REQ-037 underrun cleared only by reset.

Reset
REQ-038 rst low: immediately IDLE; rd_en, valid_flag, last_byte, busy, len_err, underrun 0; tx_data_o 8'h00; counters and prefetch cleared.
REQ-039 Reset mid-frame discards the frame; no resumption after release.

Structure
REQ-040 Package tx_pkg holds the state enumeration and default parameter constants.
REQ-041 Sub-module tx_prefetch_buf implements the 2-entry prefetch with occupancy count.

Verification
REQ-042 frm_len=64, ready high, buffer full -> 64 consecutive valid bytes, last on byte 64, 64 rd_en, then 12 idle cycles.
REQ-043 frm_len=10, PAD_EN=1 -> 10 data bytes + 54 bytes 8'h00, last on byte 64; PAD_EN=0 -> last on byte 10.
REQ-044 Ready toggled every other cycle, frm_len=70 -> data held stable while stalled, byte order intact, 70 transfers.
REQ-045 empty_buff forced high after byte 20 for 5 cycles -> valid_flag low, underrun set, frame completes correctly.
REQ-046 frm_len=0 and frm_len=1519 -> len_err pulse, no rd_en, busy stays low.
REQ-047 rst low at byte 30 of 100 -> all outputs zero same cycle; new frm_start after release sends a clean frame.
